// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// seq_divider
// Sequential unsigned restoring divider producing one quotient bit per clock.
// Computes C / B into a DW-bit quotient Q and a VW-bit remainder R.
// Division by zero completes in two edges with Q = all ones, R = C[VW-1:0] and
// dbz set.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - request, sampled only while idle
//   C      - dividend (DW bits), captured on the accepting edge
//   B      - divisor (VW bits), captured on the accepting edge
//   Q      - quotient, valid when done is high, held until the next accepted start
//   R      - remainder, valid when done is high, held until the next accepted start
//   busy   - high while an operation is in flight (state != IDLE)
//   done   - one-cycle pulse marking Q/R valid
//   dbz    - divide-by-zero flag for the last operation
module seq_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] C,
  input  logic [VW-1:0] B,
  output logic [DW-1:0] Q,
  output logic [VW-1:0] R,
  output logic          busy,
  output logic          done,
  output logic          dbz
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [VW:0]   rem_q, rem_d;     // partial remainder, one guard bit
  logic [DW-1:0] quo_q, quo_d;     // dividend shifting out / quotient shifting in
  logic [VW-1:0] div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] q_q, q_d;
  logic [VW-1:0] r_q, r_d;
  logic          done_q, done_d;
  logic          dbz_q, dbz_d;

  // One restoring step: shift the next dividend bit into the remainder and
  // try to subtract the divisor. The partial remainder entering a step is
  // always below the divisor, so the shifted value is below 2*divisor and
  // the extra borrow bit alone tells whether the subtraction went negative.
  logic [VW:0] shifted;
  logic [VW:0] trial;
  logic        borrow;

  assign shifted         = {rem_q[VW-1:0], quo_q[DW-1]};
  assign {borrow, trial} = {1'b0, shifted} - {2'b00, div_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (B != '0) begin
            rem_d   = '0;
            quo_d   = C;
            div_d   = B;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            state_d = S_CALC;
          end else begin
            // Preload the result registers so FIN publishes the dbz result
            // through the same path as a normal division.
            quo_d   = '1;
            rem_d   = {1'b0, C[VW-1:0]};
            dbz_d   = 1'b1;
            state_d = S_FIN;
          end
        end
      end

      S_CALC: begin
        if (!borrow) begin
          rem_d = trial;
          quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[DW-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DW - 1)) begin
          state_d = S_FIN;
        end
      end

      S_FIN: begin
        q_d     = quo_q;
        r_d     = rem_q[VW-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign Q    = q_q;
  assign R    = r_q;
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign dbz  = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
`timescale 1ns/1ps
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] c_in = '0;
  logic [7:0]  b_in = '0;
  logic [15:0] q_out;
  logic [7:0]  r_out;
  logic        busy;
  logic        done;
  logic        dbz;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_divider #(.DW(16), .VW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .C     (c_in),
    .B     (b_in),
    .Q     (q_out),
    .R     (r_out),
    .busy  (busy),
    .done  (done),
    .dbz   (dbz)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Caller is at a falling edge with the DUT idle (or in its done cycle).
  // Returns the number of rising edges after the accepting edge until done
  // is seen, and whether busy stayed high in every cycle before done.
  // If inj >= 0, a competing start (C=7, B=7) is pulsed after that many edges.
  task automatic run_op(input logic [15:0] c, input logic [7:0] b, input int inj,
                        output int lat, output logic busy_ok);
    start = 1'b1;
    c_in  = c;
    b_in  = b;
    @(posedge clk);
    #1;
    start   = 1'b0;
    c_in    = ~c;  // operands must have been captured already
    b_in    = ~b;
    busy_ok = busy;
    lat     = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) break;
      if (!busy) busy_ok = 1'b0;
      if (lat == inj) begin
        start = 1'b1;
        c_in  = 16'd7;
        b_in  = 8'd7;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string tag, input logic [15:0] c, input logic [7:0] b,
                       input logic [15:0] exp_q, input logic [7:0] exp_r,
                       input logic exp_dbz, input int exp_lat, input int inj);
    int   lat;
    logic busy_ok;
    run_op(c, b, inj, lat, busy_ok);
    check_eq({tag, "_latency"}, lat, exp_lat);
    check_eq({tag, "_busy_during"}, busy_ok, 1);
    check_eq({tag, "_busy_at_done"}, busy, 0);
    check_eq({tag, "_q"}, q_out, exp_q);
    check_eq({tag, "_r"}, r_out, exp_r);
    check_eq({tag, "_dbz"}, dbz, exp_dbz);
    $display("op %s: C=%0d B=%0d -> Q=%0d R=%0d dbz=%0b latency=%0d", tag, c, b, q_out, r_out, dbz, lat);
  endtask

  initial begin
    logic saw_done;
    int   lat;
    logic busy_ok;
    logic [15:0] rc;
    logic [7:0]  rb;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_q", q_out, 0);
    check_eq("rst_r", r_out, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dbz", dbz, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("basic",   16'd50000, 8'd250, 16'd200,   8'd0,   1'b0, 17, -1);
    do_op("c1000",   16'd1000,  8'd7,   16'd142,   8'd6,   1'b0, 17, -1);
    do_op("zero_c",  16'd0,     8'd5,   16'd0,     8'd0,   1'b0, 17, -1);
    do_op("max_b1",  16'd65535, 8'd1,   16'd65535, 8'd0,   1'b0, 17, -1);
    do_op("max_b255",16'd65535, 8'd255, 16'd257,   8'd0,   1'b0, 17, -1);
    do_op("c_lt_b",  16'd254,   8'd255, 16'd0,     8'd254, 1'b0, 17, -1);
    do_op("div0",    16'd1234,  8'd0,   16'hFFFF,  8'hD2,  1'b1, 1,  -1);
    do_op("after0",  16'd9,     8'd3,   16'd3,     8'd0,   1'b0, 17, -1);
    do_op("ignore",  16'd500,   8'd10,  16'd50,    8'd0,   1'b0, 17, 5);
    // Issued in the done cycle of the previous operation.
    do_op("b2b",     16'd77,    8'd7,   16'd11,    8'd0,   1'b0, 17, -1);

    // Reset in the middle of an operation.
    start = 1'b1;
    c_in  = 16'd50000;
    b_in  = 8'd250;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_q", q_out, 0);
    check_eq("midrst_r", r_out, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_dbz", dbz, 0);
    rst_n    = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check_eq("midrst_no_done", saw_done, 0);
    do_op("post_rst", 16'd100, 8'd9, 16'd11, 8'd1, 1'b0, 17, -1);

    for (int i = 0; i < 1000; i++) begin
      rc = 16'($urandom_range(0, 65535));
      rb = 8'($urandom_range(1, 255));
      run_op(rc, rb, -1, lat, busy_ok);
      check_eq("rnd_latency", lat, 17);
      check_eq("rnd_q", q_out, rc / rb);
      check_eq("rnd_r", r_out, rc % rb);
      check_eq("rnd_qbr", (32'(q_out) * 32'(rb)) + 32'(r_out), 32'(rc));
      check_eq("rnd_r_lt_b", (r_out < rb) ? 1 : 0, 1);
    end
    $display("random sweep: 1000 operations done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
